codec_intf: RTL
===============

# codec_intf

Serial audio codec interface for the equalizer datapath. It sits both upstream and downstream of the equalizer core:
- **ADC side:** generates the codec clocks and deserializes the ADC stream into 16-bit left/right samples with a `valid` strobe for the core.
- **DAC side:** serializes the core's processed left/right outputs back to the DAC.

It also sequences the codec's reset pin.

## Interface
Parameters:
- none; frame geometry (16-bit samples, 1024-clk frame) is fixed by constants in `codec_pkg`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `sdin`  in  1  serial ADC data from codec
- `dac_lft`  in  16  processed left sample from equalizer core
- `dac_rht`  in  16  processed right sample from equalizer core
- `adc_lft`  out  16  deserialized left sample to core
- `adc_rht`  out  16  deserialized right sample to core
- `valid`  out  1  one-clk strobe, new `adc_lft`/`adc_rht` pair
- `LRCLK`  out  1  frame clock, low = left half, high = right half
- `SCLK`  out  1  bit clock
- `MCLK`  out  1  codec master clock
- `codec_rst_n`  out  1  active-low codec reset
- `sdout`  out  1  serial DAC data to codec

## Operation
- **Frame counter:** free-running 10-bit `cnt`, +1 every clk, wraps 0x3FF→0x000.
- **Clock outputs:** `LRCLK=cnt[9]`, `SCLK=cnt[4]` (period 32 clk), `MCLK=cnt[1]` (period 4 clk). These are direct flop bits, so glitch-free.
- **Frame geometry:** each LRCLK half = 16 SCLK periods = 16 bits. Data is left-justified, MSB first, with no 1-bit I2S delay.
- **ADC sampling:** `sdin` is shifted into a 16-bit shift register (shift left, LSB in) when `cnt[4:0]==5'h10` (SCLK rising edge).
  - Left capture: at `cnt==0x1F1`, the shift register is copied into a left holding register.
  - Right capture: at `cnt==0x3F1`, the holding register goes to `adc_lft` and the shift register goes to `adc_rht`.
  - `valid` is registered high for exactly the cycle both outputs first show the new pair (`cnt==0x3F2`).
- **DAC serializing:** a 32-bit shift register with `sdout` = its bit 31.
  - At `cnt==0x3FF`, load `{dac_lft,dac_rht}`.
  - Else when `cnt[4:0]==5'h1F` (SCLK falling edge), shift left with 0 fill.
  - Load has priority over shift.
  - `dac_*` are sampled only at `cnt==0x3FF`; changes at any other time are ignored until the next frame.
- **Codec reset:** `codec_rst_n` stays low after reset until the first `cnt` wrap, then is high until the next `rst`.
  - `valid` is suppressed while `codec_rst_n==0`.
  - The DAC shift register still loads; `sdout` is ignored by the held-in-reset codec.

## Timing
- **Reset values:** `cnt=0`; `LRCLK`, `SCLK`, `MCLK`, `sdout`, `valid`, `codec_rst_n` = 0; `adc_lft`, `adc_rht`, all shift/holding registers = 0.
- **Reset release:** in clk cycle n after release, `cnt = n mod 1024`.
- **Codec reset deassert:** `codec_rst_n` rises at cycle 1024.
- **First `valid`:** cycle 2034 (0x3F2 of the second frame). Thereafter every 1024 clks.
- **ADC latency:** the last right bit is sampled at 0x3F0 and is on `adc_rht` at 0x3F2.
- **DAC latency:** the left MSB is on `sdout` from cycle 0x000 through the first rising SCLK at 0x010.
- **Output stability:** `adc_lft`/`adc_rht` hold stable for 1024 clks between updates.
- **Reset mid-operation:** all state returns to reset values immediately (async). The 1024-clk codec reset window restarts, and no partial sample is emitted.
- **Simultaneous events:** shift and load coincide only at 0x3FF, where load wins. Capture events never coincide with shift-in events.

## Structure
- `codec_pkg` holds: `CNT_W=10`, `SMPL_W=16`, `SAMPLE_PH=5'h10`, `SHIFT_PH=5'h1F`, `LFT_CAP=10'h1F1`, `RHT_CAP=10'h3F1`, `DAC_LOAD=10'h3FF`.
- One sub-module, `codec_clk_gen`: the counter, the `LRCLK`/`SCLK`/`MCLK` outputs, `codec_rst_n` sequencing, and the phase-decode strobes (`sample_en`, `shift_en`, `lcap`, `rcap`, `dload`).
- The serial/parallel datapath lives in `codec_intf`.

## Test plan
- **Reset/idle:** hold `rst` then release; check all outputs 0 at release, `codec_rst_n` rising exactly at cycle 1024, and no `valid` before cycle 2034.
- **Clock geometry:** over 4096 clks, check `LRCLK` period 1024, `SCLK` period 32, `MCLK` period 4, all 50% duty, with the `SCLK` rising edge at `cnt[4:0]==0x10`.
- **ADC deserialize:** a codec model drives left=0xA5C3, right=0x1234 MSB-first on SCLK falling edges. Expect `adc_lft=0xA5C3`, `adc_rht=0x1234`, and `valid` high for one clk at 2034, repeating every 1024.
- **DAC serialize:** drive `dac_lft=0x8001`, `dac_rht=0x7FFE`. The model samples `sdout` on SCLK rise and must recover 0x8001 in the LRCLK-low half and 0x7FFE in the LRCLK-high half.
- **Mid-frame DAC change:** change `dac_lft` from 0x8001 to 0x0F0F at `cnt=0x100`. The current frame still sends 0x8001 and the next frame sends 0x0F0F.
- **Reset mid-operation:** assert `rst` at cycle 1500 for 3 clks. Expect outputs at reset values, `codec_rst_n` low for 1024 clks after release, and the next `valid` 2034 clks after release.

Source files
------------

// File: rtl/codec_pkg.sv
// Frame geometry and phase-decode types shared by the codec interface blocks.
// The frame has 1024 system clocks, split into a left half and a right half of 16 bit slots each.
package codec_pkg;
    localparam int CNT_W   = 10;
    localparam int SMPL_W  = 16;
    localparam int FRAME_W = 2 * SMPL_W;

    localparam logic [4:0]       SAMPLE_PH = 5'h10;
    localparam logic [4:0]       SHIFT_PH  = 5'h1F;
    localparam logic [CNT_W-1:0] LFT_CAP   = 10'h1F1;
    localparam logic [CNT_W-1:0] RHT_CAP   = 10'h3F1;
    localparam logic [CNT_W-1:0] DAC_LOAD  = 10'h3FF;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SMPL_W-1:0] smpl_t;

    // One-clk strobes decoded from the frame counter.
    typedef struct packed {
        logic sample_en;
        logic shift_en;
        logic lcap;
        logic rcap;
        logic dload;
    } phase_t;

    function automatic logic at_bit_phase(input cnt_t cnt, input logic [4:0] ph);
        return cnt[4:0] == ph;
    endfunction
endpackage

// File: rtl/codec_clk_gen.sv
// Frame counter, codec clock outputs, codec reset sequencing and phase strobes.
// The clocks are taken straight from counter flops, so they cannot glitch.
module codec_clk_gen
    import codec_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    output logic   lrclk,
    output logic   sclk,
    output logic   mclk,
    output logic   codec_rst_n,
    output phase_t phase
);
    cnt_t cnt_q, cnt_d;
    logic codec_rst_n_q, codec_rst_n_d;

    // codec_rst_n is released by the first counter wrap and then stays high.
    always_comb begin
        cnt_d         = cnt_q + cnt_t'(1);
        codec_rst_n_d = codec_rst_n_q | (cnt_q == DAC_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            codec_rst_n_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            codec_rst_n_q <= codec_rst_n_d;
        end
    end

    assign lrclk       = cnt_q[CNT_W-1];
    assign sclk        = cnt_q[4];
    assign mclk        = cnt_q[1];
    assign codec_rst_n = codec_rst_n_q;

    always_comb begin
        phase           = '0;
        phase.sample_en = at_bit_phase(cnt_q, SAMPLE_PH);
        phase.shift_en  = at_bit_phase(cnt_q, SHIFT_PH);
        phase.lcap      = (cnt_q == LFT_CAP);
        phase.rcap      = (cnt_q == RHT_CAP);
        phase.dload     = (cnt_q == DAC_LOAD);
    end
endmodule

// File: rtl/codec_intf.sv
// Serial audio codec interface: ADC deserializer, DAC serializer and codec clocks/reset.
// Left-justified, MSB-first, 16-bit slots; the new ADC pair is announced by a one-clk valid.
module codec_intf
    import codec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sdin,
    input  logic [SMPL_W-1:0] dac_lft,
    input  logic [SMPL_W-1:0] dac_rht,
    output logic [SMPL_W-1:0] adc_lft,
    output logic [SMPL_W-1:0] adc_rht,
    output logic              valid,
    output logic              LRCLK,
    output logic              SCLK,
    output logic              MCLK,
    output logic              codec_rst_n,
    output logic              sdout
);
    phase_t phase;

    codec_clk_gen u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .lrclk       (LRCLK),
        .sclk        (SCLK),
        .mclk        (MCLK),
        .codec_rst_n (codec_rst_n),
        .phase       (phase)
    );

    smpl_t               adc_sr_q, adc_sr_d;
    smpl_t               hold_q, hold_d;
    smpl_t               adc_lft_q, adc_lft_d;
    smpl_t               adc_rht_q, adc_rht_d;
    logic                valid_q, valid_d;
    logic [FRAME_W-1:0]  dac_sr_q, dac_sr_d;

    always_comb begin
        adc_sr_d  = adc_sr_q;
        hold_d    = hold_q;
        adc_lft_d = adc_lft_q;
        adc_rht_d = adc_rht_q;
        dac_sr_d  = dac_sr_q;
        // valid lines up with the cycle the captured pair first appears on the outputs.
        valid_d   = phase.rcap & codec_rst_n;

        if (phase.sample_en) adc_sr_d = {adc_sr_q[SMPL_W-2:0], sdin};
        if (phase.lcap)      hold_d   = adc_sr_q;
        if (phase.rcap) begin
            adc_lft_d = hold_q;
            adc_rht_d = adc_sr_q;
        end

        // The frame load at the wrap takes priority over the slot shift that shares its phase.
        if (phase.dload)         dac_sr_d = {dac_lft, dac_rht};
        else if (phase.shift_en) dac_sr_d = {dac_sr_q[FRAME_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_sr_q  <= '0;
            hold_q    <= '0;
            adc_lft_q <= '0;
            adc_rht_q <= '0;
            valid_q   <= 1'b0;
            dac_sr_q  <= '0;
        end else begin
            adc_sr_q  <= adc_sr_d;
            hold_q    <= hold_d;
            adc_lft_q <= adc_lft_d;
            adc_rht_q <= adc_rht_d;
            valid_q   <= valid_d;
            dac_sr_q  <= dac_sr_d;
        end
    end

    assign adc_lft = adc_lft_q;
    assign adc_rht = adc_rht_q;
    assign valid   = valid_q;
    assign sdout   = dac_sr_q[FRAME_W-1];
endmodule
